// File: rtl/uart_tx_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_slave_if
// Brief    : Word-addressed bus command/result bundle for the UART TX slave.
// Revision : 1.0
// ============================================================================
interface uart_tx_slave_if;
    logic [29:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mask_byte;
    logic [31:0] write_data;
    logic [31:0] result;

    modport master (
        output address, mem_read, mem_write, mask_byte, write_data,
        input  result
    );

    modport slave (
        input  address, mem_read, mem_write, mask_byte, write_data,
        output result
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_slave.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_slave
// Brief    : Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Revision : 1.0
// ============================================================================
module uart_tx_slave #(
    parameter logic [15:0] DEFAULT_DIV = 16'd434,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    uart_tx_slave_if.slave  bus,
    output logic            tx_o,
    output logic            irq_empty_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e             state_q;
    logic [7:0]         shift_q;
    logic [2:0]         bit_idx_q;
    logic [15:0]        bit_cnt_q;
    logic [15:0]        div_q;
    logic               tx_q;

    logic [7:0]         fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               overflow_q;
    logic [15:0]        baud_q;

    logic [1:0]         reg_sel;
    logic               wr_txdata;
    logic               wr_status_clr;
    logic               wr_baud;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [15:0]        eff_div;
    logic [31:0]        status;
    logic               unused_bits;

    assign reg_sel       = bus.address[1:0];
    assign wr_txdata     = bus.mem_write && (reg_sel == 2'd0) && bus.mask_byte[0];
    assign wr_status_clr = bus.mem_write && (reg_sel == 2'd1) && bus.mask_byte[0]
                           && bus.write_data[3];
    assign wr_baud       = bus.mem_write && (reg_sel == 2'd2);
    assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty    = (count_q == '0);
    // Full is judged on pre-edge state, so a pop on this edge never rescues a push.
    assign push          = wr_txdata && !fifo_full;
    assign pop           = (state_q == S_IDLE) && !fifo_empty;
    assign eff_div       = (baud_q == 16'd0) ? 16'd1 : baud_q;
    assign unused_bits   = ^{bus.address[29:2], bus.mask_byte[3:2], bus.write_data[31:16]};

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= bus.write_data[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            baud_q     <= DEFAULT_DIV;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_txdata && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (wr_status_clr) begin
                overflow_q <= 1'b0;
            end
            if (wr_baud && bus.mask_byte[0]) begin
                baud_q[7:0] <= bus.write_data[7:0];
            end
            if (wr_baud && bus.mask_byte[1]) begin
                baud_q[15:8] <= bus.write_data[15:8];
            end
        end
    end

    // The divisor is latched at pop so a BAUD_DIV write only affects later frames.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            bit_cnt_q <= 16'd0;
            div_q     <= 16'd1;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q   <= fifo_mem_q[rd_ptr_q];
                        div_q     <= eff_div;
                        bit_cnt_q <= eff_div - 16'd1;
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_cnt_q == 16'd0) begin
                        bit_cnt_q <= div_q - 16'd1;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt_q == 16'd0) begin
                        bit_cnt_q <= div_q - 16'd1;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_cnt_q == 16'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        status              = 32'd0;
        status[0]           = (state_q != S_IDLE);
        status[1]           = fifo_full;
        status[2]           = fifo_empty;
        status[3]           = overflow_q;
        status[4 +: CNT_W]  = count_q;
    end

    always_comb begin
        bus.result = 32'd0;
        if (bus.mem_read) begin
            case (reg_sel)
                2'd1:    bus.result = status;
                2'd2:    bus.result = {16'd0, baud_q};
                default: bus.result = 32'd0;
            endcase
        end
    end

    assign tx_o        = tx_q;
    assign irq_empty_o = fifo_empty && (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_slave
// Brief    : Directed self-checking bench for uart_tx_slave.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_slave;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    logic irq;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] burst [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

    uart_tx_slave_if bus_if ();

    uart_tx_slave #(
        .DEFAULT_DIV (16'd434),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus_if),
        .tx_o        (tx),
        .irq_empty_o (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] m, input logic [31:0] d);
        @(negedge clk);
        bus_if.address    = {28'd0, a};
        bus_if.mask_byte  = m;
        bus_if.write_data = d;
        bus_if.mem_write  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.mem_write  = 1'b0;
        bus_if.mask_byte  = 4'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.address  = {28'd0, a};
        bus_if.mem_read = 1'b1;
        #1;
        d = bus_if.result;
        #1;
        bus_if.mem_read = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int limit, output int t);
        logic found;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        check({tag, "_start"}, {31'd0, found}, 32'd1);
        t = cyc;
    endtask

    // Called on the negedge of the first start-bit cycle; samples every cycle of the frame.
    task automatic check_frame(input string tag, input int div, input logic [7:0] b);
        logic [9:0] obs;
        logic       glitch;
        obs    = '0;
        glitch = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < div; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (c == 0) obs[k] = tx;
                else if (tx !== obs[k]) glitch = 1'b1;
            end
        end
        check(tag, {21'd0, glitch, obs}, {21'd0, 1'b0, 1'b1, b, 1'b0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int t0, t1, trans;
        logic prev;

        bus_if.address    = '0;
        bus_if.mem_read   = 1'b0;
        bus_if.mem_write  = 1'b0;
        bus_if.mask_byte  = '0;
        bus_if.write_data = '0;

        repeat (3) @(negedge clk);
        check("tx_in_reset", {31'd0, tx}, 32'd1);
        rst_n = 1'b1;

        // Reset state and register reads
        bus_read(2'd1, rd); check("rst_status", rd, 32'h04);
        bus_read(2'd2, rd); check("rst_baud", rd, 32'd434);
        bus_read(2'd0, rd); check("txdata_reads0", rd, 32'd0);
        bus_read(2'd3, rd); check("reg3_reads0", rd, 32'd0);
        @(negedge clk);
        bus_if.address = 30'd1;
        #1;
        check("result_no_read", bus_if.result, 32'd0);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd1);

        // Single byte 0x55 at DIV=4
        bus_write(2'd2, 4'b0011, 32'd4);
        bus_read(2'd2, rd); check("baud4", rd, 32'd4);
        bus_write(2'd0, 4'b0001, 32'h55);
        @(negedge clk);
        check("lat_pre_tx", {31'd0, tx}, 32'd1);
        check("irq_fall", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("lat_fall", {31'd0, tx}, 32'd0);
        check_frame("frame_55", 4, 8'h55);
        check("irq_in_stop", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, 32'd1);
        bus_read(2'd1, rd); check("status_after_55", rd, 32'h04);

        // Burst of five at DIV=2, overflow and clear
        bus_write(2'd2, 4'b0011, 32'd2);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    wait_start("burst", 200, t1);
                    check_frame("burst_frame", 2, burst[i]);
                    if (i > 0) check("burst_spacing", t1 - t0, 32'd21);
                    t0 = t1;
                end
            end
            begin
                for (int i = 0; i < 5; i++) bus_write(2'd0, 4'b0001, {24'd0, burst[i]});
                bus_read(2'd1, rd); check("status_full", rd, 32'h43);
                bus_write(2'd0, 4'b0001, 32'hFF);
                bus_read(2'd1, rd); check("status_ovf", rd, 32'h4B);
                bus_write(2'd1, 4'b0001, 32'h08);
                bus_read(2'd1, rd); check("status_ovf_clr", rd, 32'h43);
                check("irq_busy", {31'd0, irq}, 32'd0);
            end
        join
        @(negedge clk);
        check("burst_irq_end", {31'd0, irq}, 32'd1);
        bus_read(2'd1, rd); check("burst_status_end", rd, 32'h04);

        // BAUD_DIV=0 acts as 1
        bus_write(2'd2, 4'b0011, 32'd0);
        bus_read(2'd2, rd); check("baud0", rd, 32'd0);
        bus_write(2'd0, 4'b0001, 32'h00);
        wait_start("div0", 20, t1);
        check_frame("div0_frame", 1, 8'h00);

        // Mid-frame divisor change applies to the following frame
        bus_write(2'd2, 4'b0011, 32'd8);
        fork
            begin
                wait_start("div8", 50, t0);
                check_frame("div8_frame", 8, 8'h3C);
                wait_start("div3", 50, t1);
                check_frame("div3_frame", 3, 8'hC5);
                check("div8_spacing", t1 - t0, 32'd81);
            end
            begin
                bus_write(2'd0, 4'b0001, 32'h3C);
                bus_write(2'd0, 4'b0001, 32'hC5);
                repeat (10) @(negedge clk);
                bus_write(2'd2, 4'b0011, 32'd3);
                bus_read(2'd2, rd); check("baud3", rd, 32'd3);
            end
        join

        // Asynchronous reset in the middle of the DATA state
        bus_write(2'd2, 4'b0011, 32'd4);
        bus_write(2'd0, 4'b0001, 32'h00);
        bus_write(2'd0, 4'b0001, 32'h00);
        wait_start("rst", 20, t1);
        repeat (8) @(negedge clk);
        check("pre_rst_low", {31'd0, tx}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_irq", {31'd0, irq}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(2'd1, rd); check("post_rst_status", rd, 32'h04);
        bus_read(2'd2, rd); check("post_rst_baud", rd, 32'd434);
        trans = 0;
        prev  = tx;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== prev) trans++;
            prev = tx;
        end
        check("post_rst_quiet", trans, 32'd0);
        check("post_rst_tx", {31'd0, tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
